instr_fetch: RTL

Instruction fetch stage directly upstream of `controlpath`. Holds the program counter, issues word reads to instruction memory over a req/ready handshake, and presents the fetched word on `instruction`, with `wait_instr` and `instr_segv` driving the decoder's READ_INS and TRAP handling. Consumes `pc_inc` from `controlpath` and a redirect (`pc_load`/`pc_target`) from branch and trap logic.

---
 rtl/rapids_pkg.sv | 20 ++
 rtl/fetch_addr_check.sv | 19 +
 rtl/instr_fetch.sv | 107 ++++++++++
 3 files changed

// File: rtl/rapids_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rapids_pkg
// Description : Shared types and constants for the fetch pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
package rapids_pkg;

  localparam int          INSTR_W = 32;
  localparam logic [31:0] PC_STEP = 32'd4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_VALID = 2'd2,
    ST_FAULT = 2'd3
  } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/fetch_addr_check.sv
`default_nettype none
// ============================================================================
// Module      : fetch_addr_check
// Description : Combinational word-alignment and upper-bound address check.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_addr_check
  import rapids_pkg::*;
#(
  parameter logic [INSTR_W-1:0] MEM_LIMIT = 32'h0001_0000
) (
  input  logic [INSTR_W-1:0] a,
  output logic               ok
);

  assign ok = (a[1:0] == 2'b00) && (a < MEM_LIMIT);

endmodule
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch
// Description : Program counter and instruction-memory read sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch
  import rapids_pkg::*;
#(
  parameter logic [INSTR_W-1:0] RESET_PC  = 32'h0000_0000,
  parameter logic [INSTR_W-1:0] MEM_LIMIT = 32'h0001_0000
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               pc_inc,
  input  logic               pc_load,
  input  logic [INSTR_W-1:0] pc_target,
  output logic               mem_req,
  output logic [INSTR_W-1:0] mem_addr,
  input  logic               mem_ready,
  input  logic [INSTR_W-1:0] mem_rdata,
  input  logic               mem_err,
  output logic [INSTR_W-1:0] instruction,
  output logic               wait_instr,
  output logic               instr_segv,
  output logic [INSTR_W-1:0] pc
);

  fetch_state_t       r_state;
  logic [INSTR_W-1:0] r_pc;
  logic [INSTR_W-1:0] r_instr;
  logic [INSTR_W-1:0] r_redir_pc;
  logic               r_redir_pend;

  logic               w_redir_now;
  logic [INSTR_W-1:0] w_redir_pc;
  logic [INSTR_W-1:0] w_npc;
  logic               w_take;
  logic [INSTR_W-1:0] w_chk_addr;
  logic               w_ok;

  // A load arriving together with mem_ready counts as already pending.
  always_comb begin
    w_redir_now = r_redir_pend | pc_load;
    w_redir_pc  = pc_load ? pc_target : r_redir_pc;
    w_npc       = pc_load ? pc_target : (r_pc + PC_STEP);
    w_take      = pc_load | (pc_inc & (r_state == ST_VALID));
    case (r_state)
      ST_IDLE: w_chk_addr = r_pc;
      ST_REQ:  w_chk_addr = w_redir_pc;
      default: w_chk_addr = w_npc;
    endcase
  end

  fetch_addr_check #(
    .MEM_LIMIT (MEM_LIMIT)
  ) u_addr_check (
    .a  (w_chk_addr),
    .ok (w_ok)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= ST_IDLE;
      r_pc         <= RESET_PC;
      r_instr      <= '0;
      r_redir_pc   <= '0;
      r_redir_pend <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: r_state <= w_ok ? ST_REQ : ST_FAULT;
        ST_REQ: begin
          if (mem_ready) begin
            if (w_redir_now) begin
              r_pc         <= w_redir_pc;
              r_redir_pend <= 1'b0;
              r_state      <= w_ok ? ST_REQ : ST_FAULT;
            end else if (mem_err) begin
              r_state <= ST_FAULT;
            end else begin
              r_instr <= mem_rdata;
              r_state <= ST_VALID;
            end
          end else if (pc_load) begin
            r_redir_pend <= 1'b1;
            r_redir_pc   <= pc_target;
          end
        end
        default: begin
          if (w_take) begin
            r_pc    <= w_npc;
            r_state <= w_ok ? ST_REQ : ST_FAULT;
          end
        end
      endcase
    end
  end

  assign mem_req     = (r_state == ST_REQ);
  assign mem_addr    = r_pc;
  assign pc          = r_pc;
  assign instruction = r_instr;
  assign wait_instr  = (r_state == ST_IDLE) || (r_state == ST_REQ);
  assign instr_segv  = (r_state == ST_FAULT);

endmodule
`default_nettype wire
